soc_input_pio_edge: RTL and testbench



---
 rtl/soc_input_pio_edge.sv | 140 ++++++++++++++
 tb/tb_soc_input_pio_edge.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_input_pio_edge.sv
// soc_input_pio_edge: Avalon-MM slave input PIO.
// Samples an external input bus through a two-flop synchronizer, latches
// selected edges into a write-1-to-clear capture register, and raises a
// level interrupt for captured bits that are enabled in the mask register.
// Optional per-bit debounce filter: define SOC_INPUT_PIO_DEBOUNCE_EN.
module soc_input_pio_edge #(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [WIDTH-1:0] s1_reg;
  logic [WIDTH-1:0] s2_reg;
  logic [WIDTH-1:0] v;
  logic [WIDTH-1:0] p_reg;
  logic [WIDTH-1:0] edge_bits;
  logic [WIDTH-1:0] mask_reg;
  logic [WIDTH-1:0] mask_next;
  logic [WIDTH-1:0] cap_reg;
  logic [WIDTH-1:0] cap_next;
  logic             wr_mask;
  logic             wr_cap;

  // Two-flop synchronizer for the asynchronous external inputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= in_port;
      s2_reg <= s1_reg;
    end
  end

`ifdef SOC_INPUT_PIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_debounce
    logic             f_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Filtered bit follows s2 only after it has differed for DEBOUNCE_CYCLES clocks
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        f_reg   <= 1'b0;
        cnt_reg <= '0;
      end else if (s2_reg[gi] == f_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        f_reg   <= s2_reg[gi];
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end

    assign v[gi] = f_reg;
  end
`else
  assign v = s2_reg;
`endif

  // Previous-value register used by the edge detector
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_reg <= '0;
    end else begin
      p_reg <= v;
    end
  end

  // Edge selection: 0 = rising, 1 = falling, anything else = both
  always_comb begin
    case (EDGE_TYPE)
      0:       edge_bits = v & ~p_reg;
      1:       edge_bits = ~v & p_reg;
      default: edge_bits = v ^ p_reg;
    endcase
  end

  assign wr_mask = chipselect & ~write_n & (address == ADDR_MASK);
  assign wr_cap  = chipselect & ~write_n & (address == ADDR_EDGECAP);

  // Next-state for mask and capture; a new edge beats a simultaneous clear
  always_comb begin
    mask_next = mask_reg;
    cap_next  = cap_reg | edge_bits;
    if (wr_mask) begin
      mask_next = writedata[WIDTH-1:0];
    end
    if (wr_cap) begin
      cap_next = (cap_reg & ~writedata[WIDTH-1:0]) | edge_bits;
    end
  end

  // Mask and capture registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_reg <= '0;
      cap_reg  <= '0;
    end else begin
      mask_reg <= mask_next;
      cap_reg  <= cap_next;
    end
  end

  // Zero-wait-state read mux, upper bits always zero
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = v;
      ADDR_MASK:    readdata[WIDTH-1:0] = mask_reg;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = cap_reg;
      default:      readdata = '0;
    endcase
  end

  assign irq = |(cap_reg & mask_reg);

  // Upper write-data bits and the filter length are not used in every build
  logic unused_bits;
  assign unused_bits = ^{writedata, DEBOUNCE_CYCLES};

endmodule

// File: tb/tb_soc_input_pio_edge.sv
// Self-checking bench for soc_input_pio_edge: a rising-edge instance and an
// any-edge instance share the bus and inputs; each has its own outputs.
`timescale 1ns/1ps
module tb_soc_input_pio_edge;

`ifdef SOC_INPUT_PIO_DEBOUNCE_EN
  localparam int DLAT = 16;
`else
  localparam int DLAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [3:0]  in_port = 4'd0;
  logic [31:0] rd_rise;
  logic [31:0] rd_any;
  logic        irq_rise;
  logic        irq_any;

  always #5 clk = ~clk;

  soc_input_pio_edge #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_rise), .irq(irq_rise)
  );

  soc_input_pio_edge #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(16)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_any), .irq(irq_any)
  );

  typedef struct {
    int          inst;
    logic [31:0] rd;
    logic        irq;
    string       name;
  } exp_t;

  typedef struct {
    logic        we;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    string       name;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[10];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic we, logic [1:0] a, logic [31:0] wd,
                              logic [31:0] exp_rd, string name);
    vec_t r;
    r.we = we; r.a = a; r.wd = wd; r.exp_rd = exp_rd; r.name = name;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic compare_pending();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({e.name, ".rd"},  (e.inst == 2) ? rd_any : rd_rise, e.rd);
      check({e.name, ".irq"}, {31'd0, (e.inst == 2) ? irq_any : irq_rise}, {31'd0, e.irq});
    end
  endtask

  // Read: drive the address, queue the expectation, compare 1 ns later
  task automatic rd(int inst, logic [1:0] a, logic [31:0] e_rd, logic e_irq, string name);
    exp_t e;
    address = a;
    chipselect = 1'b1;
    write_n = 1'b1;
    e.inst = inst; e.rd = e_rd; e.irq = e_irq; e.name = name;
    sb_q.push_back(e);
    #1;
    compare_pending();
    chipselect = 1'b0;
  endtask

  // Write: one bus cycle, returns at the following falling edge
  task automatic wr(logic [1:0] a, logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n = 1'b1;
    writedata = 32'd0;
  endtask

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] tog_in [3];
    logic [3:0] tog_rise [3];

    tbl[0] = mk(1'b0, 2'd0, 32'h0,        32'h0, "rst_data");
    tbl[1] = mk(1'b0, 2'd1, 32'h0,        32'h0, "rst_rsvd");
    tbl[2] = mk(1'b0, 2'd2, 32'h0,        32'h0, "rst_mask");
    tbl[3] = mk(1'b0, 2'd3, 32'h0,        32'h0, "rst_cap");
    tbl[4] = mk(1'b1, 2'd2, 32'hFFFFFFF3, 32'h3, "mask_trunc");
    tbl[5] = mk(1'b1, 2'd0, 32'h0000000F, 32'h0, "wr_data_ignored");
    tbl[6] = mk(1'b1, 2'd1, 32'h0000000F, 32'h0, "wr_rsvd_ignored");
    tbl[7] = mk(1'b0, 2'd2, 32'h0,        32'h3, "mask_kept");
    tbl[8] = mk(1'b1, 2'd3, 32'h0000000F, 32'h0, "cap_w1c_idle");
    tbl[9] = mk(1'b1, 2'd2, 32'h00000001, 32'h1, "mask_set");

    tog_in[0] = 4'h1; tog_rise[0] = 4'h0;
    tog_in[1] = 4'h5; tog_rise[1] = 4'h4;
    tog_in[2] = 4'h1; tog_rise[2] = 4'h0;

    cycles(3);
    reset_n = 1'b1;
    cycles(1);

    // Register map and reset values
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].we) wr(tbl[i].a, tbl[i].wd);
      rd(0, tbl[i].a, tbl[i].exp_rd, 1'b0, tbl[i].name);
      cycles(1);
    end
    rd(2, 2'd2, 32'h1, 1'b0, "any_mask");
    cycles(1);

    // Latency: DATA after two edges, capture and irq after three
    in_port = 4'b0101;
    rd(0, 2'd0, 32'h0, 1'b0, "lat_data_pre");
    cycles(1 + DLAT);
    rd(0, 2'd0, 32'h0, 1'b0, "lat_data_e1");
    cycles(1);
    rd(0, 2'd0, 32'h5, 1'b0, "lat_data_e2");
    rd(0, 2'd3, 32'h0, 1'b0, "lat_cap_e2");
    cycles(1);
    rd(0, 2'd3, 32'h5, 1'b1, "lat_cap_e3");
    rd(2, 2'd3, 32'h5, 1'b1, "any_cap_e3");
    wr(2'd3, 32'h1);
    rd(0, 2'd3, 32'h4, 1'b0, "w1c_bit0");
    rd(2, 2'd3, 32'h4, 1'b0, "any_w1c_bit0");
    wr(2'd3, 32'hF);

    // Bit 2 toggles: rising instance sees only the rise, any-edge sees both
    for (int k = 0; k < 3; k++) begin
      in_port = tog_in[k];
      cycles(12 + DLAT);
      rd(0, 2'd3, {28'd0, tog_rise[k]}, 1'b0, $sformatf("toggle%0d_rise", k));
      rd(2, 2'd3, 32'h4, 1'b0, $sformatf("toggle%0d_any", k));
      wr(2'd3, 32'hF);
    end

    // Clear lands on the same clock as a new rising edge on bit 2
    in_port = 4'h5;
    cycles(2 + DLAT);
    wr(2'd3, 32'h4);
    rd(0, 2'd3, 32'h4, 1'b0, "clr_vs_set_rise");
    rd(2, 2'd3, 32'h4, 1'b0, "clr_vs_set_any");
    cycles(5);
    rd(0, 2'd3, 32'h4, 1'b0, "clr_vs_set_hold");
    wr(2'd3, 32'hF);

    // Reset in the middle of operation with cap and mask full
    wr(2'd2, 32'hF);
    in_port = 4'h0;
    cycles(12 + DLAT);
    wr(2'd3, 32'hF);
    in_port = 4'hF;
    cycles(3 + DLAT);
    rd(0, 2'd3, 32'hF, 1'b1, "pre_rst_cap");
    rd(2, 2'd3, 32'hF, 1'b1, "pre_rst_any");
    #1;
    reset_n = 1'b0;
    #1;
    check("async_rst_irq_rise", {31'd0, irq_rise}, 32'h0);
    check("async_rst_irq_any",  {31'd0, irq_any},  32'h0);
    check("async_rst_cap",      rd_rise,           32'h0);
    cycles(2);
    reset_n = 1'b1;
    cycles(1 + DLAT);
    rd(0, 2'd0, 32'h0, 1'b0, "rel_data_e1");
    cycles(1);
    rd(0, 2'd0, 32'hF, 1'b0, "rel_data_e2");
    rd(0, 2'd3, 32'h0, 1'b0, "rel_cap_e2");
    cycles(1);
    rd(0, 2'd3, 32'hF, 1'b0, "rel_cap_e3");
    rd(0, 2'd2, 32'h0, 1'b0, "rel_mask");
    wr(2'd3, 32'hF);
    cycles(6);
    rd(0, 2'd3, 32'h0, 1'b0, "rel_no_more_rise");
    rd(2, 2'd3, 32'h0, 1'b0, "rel_no_more_any");

`ifdef SOC_INPUT_PIO_DEBOUNCE_EN
    // Debounce: short glitch rejected, long pulse accepted after 16 clocks
    in_port = 4'h0;
    cycles(40);
    wr(2'd3, 32'hF);
    wr(2'd2, 32'h1);
    cycles(1);
    in_port = 4'h1;
    cycles(10);
    in_port = 4'h0;
    cycles(30);
    rd(0, 2'd0, 32'h0, 1'b0, "glitch_data");
    rd(0, 2'd3, 32'h0, 1'b0, "glitch_cap");
    rd(2, 2'd3, 32'h0, 1'b0, "glitch_cap_any");
    cycles(1);
    in_port = 4'h1;
    cycles(17);
    rd(0, 2'd0, 32'h0, 1'b0, "db_data_before");
    cycles(1);
    rd(0, 2'd0, 32'h1, 1'b0, "db_data_after16");
    rd(0, 2'd3, 32'h0, 1'b0, "db_cap_not_yet");
    cycles(1);
    rd(0, 2'd3, 32'h1, 1'b1, "db_cap");
    cycles(2);
    in_port = 4'h0;
    cycles(5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
